imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Upstream feeder for the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives a one-word-per-pulse write port into instruction memory.
- Holds the core in reset (core_rst) while a program is loading; releases it once the image is complete.
- Detects oversize images and stalled transfers, reporting them on err_code.

Parameters:
- DEPTH_WORDS, 64: instruction memory capacity in 32-bit words.
- ADDR_W, 6: word-address width; must equal clog2(DEPTH_WORDS).
- TIMEOUT_CYC, 1024: maximum idle cycles between accepted bytes while loading.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  single-cycle pulse that begins a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address (byte address = imem_addr*4).
- imem_wdata  output  32  assembled instruction word.
- core_rst  output  1  reset request to the core; high means hold the core in reset.
- busy  output  1  high while in LEN0, LEN1 or DATA.
- done  output  1  last load completed successfully.
- err_code  output  2  0 = none, 1 = length overflow, 2 = timeout.

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err_code=0. State = IDLE; word counter, byte index and timeout counter cleared.
- States: IDLE, LEN0, LEN1, DATA, DONE, ERR.
- load_start is honoured only in IDLE, DONE or ERR. On the next cycle:
  - state = LEN0;
  - done=0, err_code=0, core_rst=1, word counter=0.
  - load_start while busy is ignored.
- rx_ready = 1 exactly when the state is LEN0, LEN1 or DATA. In IDLE it is 0, so a byte presented in the same cycle as load_start is not consumed.
- LEN0: accepted byte -> N[7:0]; go to LEN1.
- LEN1: accepted byte -> N[15:8], then:
  - N == 0 -> DONE; no writes.
  - N > DEPTH_WORDS -> ERR with err_code=1.
  - otherwise -> DATA with byte index 0.
- DATA: bytes arrive LSB first. Byte k (0..3) goes into word bits [8k+7:8k].
  - On acceptance of byte 3, in the next cycle: imem_we=1, imem_addr=word counter, imem_wdata=the assembled word. The word counter then increments.
  - imem_we is high for exactly one cycle per word.
  - imem_addr and imem_wdata hold their last values while imem_we is low.
- Throughput: one byte per cycle is sustained. Back-to-back words are allowed, giving imem_we high every 4th cycle.
- Completion: when the written word is word N-1, the state moves to DONE in the same cycle imem_we is high. rx_ready=0 from that cycle on.
- DONE: done=1 and core_rst=0, both held until the next load_start or rst.
- Timeout:
  - In LEN0, LEN1 and DATA, a counter increments on every cycle with no transfer and clears on every transfer.
  - When it reaches TIMEOUT_CYC -> ERR with err_code=2.
  - A partial word is discarded; no imem_we is issued for it.
- ERR: core_rst=1, done=0, rx_ready=0; err_code holds until load_start or rst.
- Reset mid-load: everything returns to its reset values the next cycle. No write is issued for a partial word. Memory contents already written are left untouched; the loader never clears memory.
- Bytes arriving after completion are not accepted (rx_ready=0). The upstream source owns any surplus bytes.

Test Plan:
1. rst held 2 cycles, then released -> core_rst=1, done=0, rx_ready=0, err_code=0.
2. load_start, then bytes 02 00 13 05 A0 00 93 05 10 00 at one per cycle with no gaps:
   - imem_we pulses at addr 0 with 0x00A00513, then at addr 1 with 0x00100593;
   - done=1 and core_rst=0 one cycle after the second pulse.
3. load_start, then length bytes 00 00 -> DONE with no imem_we; core_rst=0.
4. load_start, then length 41 00 (65 > 64) -> err_code=1, core_rst=1, rx_ready=0, no writes.
5. load_start, length 01 00, then 2 data bytes, then 1024 idle cycles -> err_code=2, no imem_we; a following load_start clears err_code.
6. Mid-word rst during DATA -> all outputs at reset values the next cycle, no write. Also: load_start asserted during DATA is ignored and the load completes normally. Also: random rx_valid gaps under 1024 cycles produce the same words as in scenario 2.

Source files
------------

// File: rtl/imem_program_loader.sv
// Byte-stream loader for the core's instruction memory: takes a 16-bit word count and then
// little-endian words, writes one word per pulse, and holds the core in reset until the image is complete.
module imem_program_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code
);
    // state | meaning
    // IDLE  | after reset, waiting for load_start
    // LEN0  | expecting length byte N[7:0]
    // LEN1  | expecting length byte N[15:8]
    // DATA  | receiving instruction bytes, LSB first
    // DONE  | image complete, core released
    // ERR   | oversize image or timeout, core held in reset
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR
    } state_t;

    state_t          state;
    logic [7:0]      len_lo;
    logic [15:0]     len_words;
    logic [15:0]     word_cnt;
    logic [1:0]      byte_idx;
    logic [23:0]     word_buf;
    logic [TO_W-1:0] idle_cnt;
    logic [15:0]     len_next;
    logic            xfer;

    assign busy     = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
    assign rx_ready = busy;
    assign xfer     = rx_valid && rx_ready;
    assign len_next = {rx_data, len_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len_lo     <= '0;
            len_words  <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            idle_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (state == S_DONE) begin
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end
                    // a new load overrides whatever status the previous one left behind
                    if (load_start) begin
                        state    <= S_LEN0;
                        done     <= 1'b0;
                        err_code <= 2'd0;
                        core_rst <= 1'b1;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        idle_cnt <= '0;
                    end
                end
                S_LEN0, S_LEN1, S_DATA: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        state    <= S_ERR;
                        err_code <= 2'd2;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end

                    if (xfer) begin
                        case (state)
                            S_LEN0: begin
                                len_lo <= rx_data;
                                state  <= S_LEN1;
                            end
                            S_LEN1: begin
                                len_words <= len_next;
                                if (len_next == 16'd0) begin
                                    state <= S_DONE;
                                end else if (len_next > 16'(DEPTH_WORDS)) begin
                                    state    <= S_ERR;
                                    err_code <= 2'd1;
                                end else begin
                                    state    <= S_DATA;
                                    byte_idx <= '0;
                                end
                            end
                            default: begin
                                byte_idx <= byte_idx + 1'b1;
                                case (byte_idx)
                                    2'd0: word_buf[7:0]   <= rx_data;
                                    2'd1: word_buf[15:8]  <= rx_data;
                                    2'd2: word_buf[23:16] <= rx_data;
                                    default: begin
                                        imem_we    <= 1'b1;
                                        imem_addr  <= word_cnt[ADDR_W-1:0];
                                        imem_wdata <= {rx_data, word_buf};
                                        word_cnt   <= word_cnt + 16'd1;
                                        if (word_cnt == len_words - 16'd1)
                                            state <= S_DONE;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: normal load, empty and oversize images,
// timeout, reset mid-word, ignored load_start while busy, and gapped input.
module tb_imem_program_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int wr_base;

    imem_program_loader #(.DEPTH_WORDS(64), .ADDR_W(6), .TIMEOUT_CYC(1024)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
        .busy(busy), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) wr_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Two-word program from the reference image; optional random gaps and a stray load_start mid-data.
    task automatic run_prog(input string tag, input int maxgap, input bit inject);
        logic [7:0] prog [10];
        prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        wr_base = wr_cnt;
        start_load();
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_err_clr"}, {30'd0, err_code}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, maxgap)) step();
            if (inject && i == 4) load_start = 1'b1;
            send(prog[i]);
            load_start = 1'b0;
            if (i == 5) begin
                check({tag, "_we0"}, {31'd0, imem_we}, 32'd1);
                check({tag, "_addr0"}, {26'd0, imem_addr}, 32'd0);
                check({tag, "_data0"}, imem_wdata, 32'h00A00513);
            end
            if (i == 6) check({tag, "_we_one_cycle"}, {31'd0, imem_we}, 32'd0);
        end
        check({tag, "_we1"}, {31'd0, imem_we}, 32'd1);
        check({tag, "_addr1"}, {26'd0, imem_addr}, 32'd1);
        check({tag, "_data1"}, imem_wdata, 32'h00100593);
        check({tag, "_ready_off"}, {31'd0, rx_ready}, 32'd0);
        step();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        check({tag, "_we_low"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_nwrites"}, wr_cnt - wr_base, 32'd2);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_err", {30'd0, err_code}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        run_prog("prog", 0, 1'b0);

        // empty image; a byte offered together with load_start must not be taken
        wr_base = wr_cnt;
        rx_data = 8'h07; rx_valid = 1'b1;
        start_load();
        rx_valid = 1'b0;
        send(8'h00); send(8'h00);
        check("empty_ready", {31'd0, rx_ready}, 32'd0);
        step();
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_core_rst", {31'd0, core_rst}, 32'd0);
        check("empty_nwrites", wr_cnt - wr_base, 32'd0);

        // oversize image
        wr_base = wr_cnt;
        start_load();
        check("ovf_done_clr", {31'd0, done}, 32'd0);
        send(8'h41); send(8'h00);
        check("ovf_err", {30'd0, err_code}, 32'd1);
        check("ovf_core_rst", {31'd0, core_rst}, 32'd1);
        check("ovf_ready", {31'd0, rx_ready}, 32'd0);
        step();
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_nwrites", wr_cnt - wr_base, 32'd0);

        // timeout after a partial word
        wr_base = wr_cnt;
        start_load();
        check("to_err_clr", {30'd0, err_code}, 32'd0);
        send(8'h01); send(8'h00); send(8'hDE); send(8'hAD);
        repeat (1023) step();
        check("to_not_yet", {30'd0, err_code}, 32'd0);
        check("to_still_busy", {31'd0, busy}, 32'd1);
        step();
        check("to_err", {30'd0, err_code}, 32'd2);
        check("to_ready", {31'd0, rx_ready}, 32'd0);
        check("to_core_rst", {31'd0, core_rst}, 32'd1);
        check("to_nwrites", wr_cnt - wr_base, 32'd0);
        start_load();
        check("to_restart_err", {30'd0, err_code}, 32'd0);

        // reset in the middle of a word
        wr_base = wr_cnt;
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB); send(8'hCC);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("mid_rst_we", {31'd0, imem_we}, 32'd0);
        check("mid_rst_addr", {26'd0, imem_addr}, 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        check("mid_rst_nwrites", wr_cnt - wr_base, 32'd0);

        run_prog("inject", 0, 1'b1);
        run_prog("gaps", 6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
